serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B - Bin, one bit per clock,
// with valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting one bit per cycle through the subtractor cell
// DONE  | result held with out_valid high until out_ready
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_sa;
  logic             r_sb;
  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
            r_sa     <= A[WIDTH-1];
            r_sb     <= B[WIDTH-1];
          end
        end
        RUN: begin
          // Result fills from the MSB end so bit 0 lands at index 0 after WIDTH shifts.
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (r_cnt == LAST) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign D    = r_res;
  assign Bout = r_borrow;
  assign V    = (r_sa ^ r_sb) & (r_sa ^ r_res[WIDTH-1]);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed literal cases plus a random sweep
// checked every cycle against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;

  logic         or_force = 1'b1;
  logic         rnd_mode = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;
  logic prev_ov = 1'b0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    e.d    = full[W-1:0];
    e.bout = full[W];
    e.v    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.d[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // out_ready is driven from one place; random in the sweep, forced otherwise.
  always @(posedge clk) begin
    #2;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : or_force;
  end

  // Reference model: capture each accepted operand set, retire on handshake.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        q.push_back(model(A, B, Bin));
        t_acc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check("model_D", 32'(D), 32'(q[0].d));
          check("model_Bout", 32'(Bout), 32'(q[0].bout));
          check("model_V", 32'(V), 32'(q[0].v));
        end
        if (!prev_ov) check("latency", 32'(cyc - t_acc), 32'(W));
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bit ok = 0;
    in_valid = 1'b1;
    A = a; B = b; Bin = bin;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
      end
    end
    #1 in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_out(output bit seen);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) check("out_valid_timeout", 32'd1, 32'd0);
  endtask

  // Directed op with out_ready high: literal result and in_ready low-time.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] ed, input logic eb, input logic ev,
                       input string name);
    int  busy = 0;
    bit  seen = 0;
    bit  back = 0;
    send(a, b, bin);
    for (int i = 0; i < 100 && !back; i++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1;
        check({name, "_D"}, 32'(D), 32'(ed));
        check({name, "_Bout"}, 32'(Bout), 32'(eb));
        check({name, "_V"}, 32'(V), 32'(ev));
      end
      if (in_ready) back = 1;
      else busy++;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy), 32'(W + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [W-1:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_V", 32'(V), 32'd0);
    @(posedge clk); #1;

    do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "sub_5A_3C");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "sub_00_01");
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "sub_10_0F_b");
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_00_00_b");

    // Back-pressure: hold the result, then queue a second op behind it.
    or_force = 1'b0;
    send(8'h33, 8'h44, 1'b0);
    wait_out(seen);
    @(posedge clk); #1;
    in_valid = 1'b1; A = 8'h7F; B = 8'h80; Bin = 1'b0;
    held = D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_D", 32'(D), 32'h000000EF);
      check("bp_D_stable", 32'(D), 32'(held));
    end
    @(posedge clk); #1 or_force = 1'b1;
    @(negedge clk);
    check("bp_pre_hs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_post_hs_in_ready", 32'(in_ready), 32'd1);
    check("bp_post_hs_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(seen);
    check("bp2_D", 32'(D), 32'h000000FF);
    check("bp2_Bout", 32'(Bout), 32'd1);
    check("bp2_V", 32'(V), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in the middle of RUN discards the operation.
    send(8'h5A, 8'h3C, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_D", 32'(D), 32'd0);
    check("midrst_Bout", 32'(Bout), 32'd0);
    @(posedge clk); #1;
    do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "after_rst");

    // Random sweep with random back-pressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    rnd_mode = 1'b0;
    begin
      bit drained = 0;
      for (int i = 0; i < 200 && !drained; i++) begin
        @(negedge clk);
        if (q.size() == 0 && in_ready) drained = 1;
      end
      check("final_drain", 32'(drained), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
